// File: rtl/mc_datapath_regs.sv
// Multi-cycle datapath register bank: PC, IR, MDR, A, B, ALUOut, plus the
// address, operand, write-back and next-PC muxes wrapped around them.
module mc_datapath_regs #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegDst,
  input  logic             Memwrite,
  input  logic             Memread,
  input  logic [1:0]       Memtoreg,
  input  logic             PCwrite_cond,
  input  logic             PCwrite,
  input  logic [1:0]       PCsrc,
  input  logic             ALUsrcA,
  input  logic [1:0]       ALUsrcB,
  input  logic             IRwrite,
  input  logic             IorD,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [6:0]       op_code,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CNT_W-1:0] fetch_count,
  output logic             pcsrc_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] ir_reg, ir_next;
  logic [WIDTH-1:0] mdr_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] alu_out_reg;
  logic [CNT_W-1:0] fetch_count_reg, fetch_count_next;
  logic             pcsrc_err_reg, pcsrc_err_next;

  logic             pc_we;
  logic [11:0]      imm12;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] imm_sh;

  assign op_code = ir_reg[6:0];

  always_comb begin
    imm12 = 12'd0;
    case (op_code)
      OP_LOAD, OP_IMM, OP_JALR: imm12 = ir_reg[31:20];
      OP_STORE:                 imm12 = {ir_reg[31:25], ir_reg[11:7]};
      // Branch offsets are stored in half-words; the <<1 path restores bit 0.
      OP_BRANCH:                imm12 = {ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8]};
      default:                  imm12 = 12'd0;
    endcase
  end

  assign imm    = {{(WIDTH-12){imm12[11]}}, imm12};
  assign imm_sh = {imm[WIDTH-2:0], 1'b0};

  assign pc_we = PCwrite | (PCwrite_cond & alu_zero);

  // PCsrc=11 is illegal: PC holds and the sticky error flag records it.
  always_comb begin
    pc_next        = pc_reg;
    pcsrc_err_next = pcsrc_err_reg;
    if (pc_we) begin
      case (PCsrc)
        2'b00:   pc_next = alu_result;
        2'b01:   pc_next = alu_out_reg;
        2'b10:   pc_next = {alu_result[WIDTH-1:1], 1'b0};
        default: pcsrc_err_next = 1'b1;
      endcase
    end
  end

  always_comb begin
    ir_next          = ir_reg;
    fetch_count_next = fetch_count_reg;
    if (IRwrite) begin
      ir_next          = mem_rdata;
      fetch_count_next = fetch_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      ir_reg          <= '0;
      mdr_reg         <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      alu_out_reg     <= '0;
      fetch_count_reg <= '0;
      pcsrc_err_reg   <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      ir_reg          <= ir_next;
      mdr_reg         <= mem_rdata;
      a_reg           <= rf_rdata1;
      b_reg           <= rf_rdata2;
      alu_out_reg     <= alu_result;
      fetch_count_reg <= fetch_count_next;
      pcsrc_err_reg   <= pcsrc_err_next;
    end
  end

  assign mem_addr  = IorD ? alu_out_reg : pc_reg;
  assign mem_wdata = b_reg;
  assign mem_we    = Memwrite;
  assign mem_re    = Memread;

  assign rf_raddr1 = ir_reg[19:15];
  assign rf_raddr2 = ir_reg[24:20];
  assign rf_waddr  = RegDst ? ir_reg[11:7] : ir_reg[24:20];

  always_comb begin
    rf_wdata = '0;
    case (Memtoreg)
      2'b00:   rf_wdata = alu_out_reg;
      2'b01:   rf_wdata = mdr_reg;
      2'b10:   rf_wdata = pc_reg;
      default: rf_wdata = '0;
    endcase
  end

  assign alu_a = ALUsrcA ? a_reg : pc_reg;

  always_comb begin
    alu_b = b_reg;
    case (ALUsrcB)
      2'b00:   alu_b = b_reg;
      2'b01:   alu_b = WIDTH'(4);
      2'b10:   alu_b = imm;
      default: alu_b = imm_sh;
    endcase
  end

  assign fetch_count = fetch_count_reg;
  assign pcsrc_err   = pcsrc_err_reg;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Scoreboard bench for mc_datapath_regs: expectations are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_mc_datapath_regs;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             RegDst, Memwrite, Memread, PCwrite_cond, PCwrite;
  logic             ALUsrcA, IRwrite, IorD, alu_zero;
  logic [1:0]       Memtoreg, PCsrc, ALUsrcB;
  logic [WIDTH-1:0] mem_rdata, rf_rdata1, rf_rdata2, alu_result;
  logic [6:0]       op_code;
  logic [WIDTH-1:0] mem_addr, mem_wdata, rf_wdata, alu_a, alu_b;
  logic             mem_we, mem_re, pcsrc_err;
  logic [4:0]       rf_raddr1, rf_raddr2, rf_waddr;
  logic [CNT_W-1:0] fetch_count;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] fc_m   = 0;

  mc_datapath_regs #(.WIDTH(WIDTH), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegDst(RegDst), .Memwrite(Memwrite), .Memread(Memread), .Memtoreg(Memtoreg),
    .PCwrite_cond(PCwrite_cond), .PCwrite(PCwrite), .PCsrc(PCsrc),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .IRwrite(IRwrite), .IorD(IorD),
    .mem_rdata(mem_rdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .op_code(op_code), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
    .fetch_count(fetch_count), .pcsrc_err(pcsrc_err)
  );

  always #5 clk = ~clk;

  task automatic push(input string n, input logic [31:0] v);
    exp_t x;
    x.name = n;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic ctrl_idle();
    RegDst = 0; Memwrite = 0; Memread = 0; Memtoreg = 2'b00; PCwrite_cond = 0;
    PCwrite = 0; PCsrc = 2'b00; ALUsrcA = 0; ALUsrcB = 2'b00; IRwrite = 0;
    IorD = 0; alu_zero = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    ctrl_idle();
    mem_rdata = 32'h00A00093; alu_result = 32'h1234; rf_rdata1 = 32'h5; rf_rdata2 = 32'h6;
    repeat (2) step();
    push("rst_pc", 32'h0); push("rst_alu_out", 32'h0);
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    IorD = 1; #1;
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    IorD = 0;
    @(negedge clk);
    rst = 1; alu_result = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    push("rel_pc", 32'h0); push("rel_op", 32'h0); push("rel_fc", 32'h0); push("rel_err", 32'h0);
    step();
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(op_code) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, op_code, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(fetch_count) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, fetch_count, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(pcsrc_err) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, pcsrc_err, e.val); end
    $display("reset released: pc=%h op=%h fc=%0d", mem_addr, op_code, fetch_count);
  endtask

  task automatic test_fetch();
    IRwrite = 1; PCwrite = 1; PCsrc = 2'b00; ALUsrcA = 0; ALUsrcB = 2'b01;
    alu_result = 32'h4; mem_rdata = 32'h00A00093;
    #1;
    push("fetch_alu_b", 32'h4); push("fetch_alu_a", 32'h0);
    e = sb.pop_front(); checks++;
    if (alu_b !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, alu_b, e.val); end
    e = sb.pop_front(); checks++;
    if (alu_a !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, alu_a, e.val); end
    fc_m = (fc_m + 1) & 32'hF;
    push("fetch_pc", 32'h4); push("fetch_op", 32'h13); push("fetch_fc", fc_m);
    step();
    IRwrite = 0; PCwrite = 0;
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(op_code) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, op_code, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(fetch_count) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, fetch_count, e.val); end
    // 00A00093 = addi x1, x0, 10
    push("addi_imm", 32'd10); push("addi_imm_sh", 32'd20); push("addi_rt", 32'd10);
    push("addi_rd", 32'd1); push("addi_rs1", 32'd0);
    ALUsrcB = 2'b10; #1;
    e = sb.pop_front(); checks++;
    if (alu_b !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, alu_b, e.val); end
    ALUsrcB = 2'b11; #1;
    e = sb.pop_front(); checks++;
    if (alu_b !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, alu_b, e.val); end
    RegDst = 0; #1;
    e = sb.pop_front(); checks++;
    if (32'(rf_waddr) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_waddr, e.val); end
    RegDst = 1; #1;
    e = sb.pop_front(); checks++;
    if (32'(rf_waddr) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_waddr, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(rf_raddr1) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_raddr1, e.val); end
    ctrl_idle();
    $display("fetch: pc=%h op=%h fc=%0d", mem_addr, op_code, fetch_count);
  endtask

  task automatic test_imm_decode();
    logic [31:0] irs[7];
    logic [31:0] imms[7];
    logic [31:0] shs[7];
    irs[0] = {7'h7F, 5'd2, 5'd1, 3'b010, 5'b11000, 7'b0100011};         imms[0] = 32'hFFFF_FFF8; shs[0] = 32'hFFFF_FFF0;
    irs[1] = {1'b0, 6'b0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'b1100011}; imms[1] = 32'h4;         shs[1] = 32'h8;
    irs[2] = {1'b1, 6'h3F, 5'd2, 5'd1, 3'b001, 4'b1110, 1'b1, 7'b1100011}; imms[2] = 32'hFFFF_FFFE; shs[2] = 32'hFFFF_FFFC;
    irs[3] = {12'hFFF, 5'd3, 3'b010, 5'd4, 7'b0000011};                 imms[3] = 32'hFFFF_FFFF; shs[3] = 32'hFFFF_FFFE;
    irs[4] = {12'h123, 5'd1, 3'b000, 5'd0, 7'b1100111};                 imms[4] = 32'h123;       shs[4] = 32'h246;
    irs[5] = {7'h7F, 5'd31, 5'd31, 3'b111, 5'd31, 7'b0110011};          imms[5] = 32'h0;         shs[5] = 32'h0;
    irs[6] = {20'hFFFFF, 5'd5, 7'b0110111};                             imms[6] = 32'h0;         shs[6] = 32'h0;
    for (int i = 0; i < 7; i++) begin
      mem_rdata = irs[i]; IRwrite = 1;
      fc_m = (fc_m + 1) & 32'hF;
      push("dec_op", {25'd0, irs[i][6:0]}); push("dec_fc", fc_m);
      push("dec_imm", imms[i]); push("dec_imm_sh", shs[i]);
      push("dec_rs2", {27'd0, irs[i][24:20]});
      step();
      IRwrite = 0;
      e = sb.pop_front(); checks++;
      if (32'(op_code) !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, op_code, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(fetch_count) !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, fetch_count, e.val); end
      ALUsrcB = 2'b10; #1;
      e = sb.pop_front(); checks++;
      if (alu_b !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, alu_b, e.val); end
      ALUsrcB = 2'b11; #1;
      e = sb.pop_front(); checks++;
      if (alu_b !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, alu_b, e.val); end
      e = sb.pop_front(); checks++;
      if (32'(rf_raddr2) !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, rf_raddr2, e.val); end
      ALUsrcB = 2'b00;
      $display("decode ir=%h op=%h imm=%h", irs[i], op_code, alu_b);
    end
  endtask

  task automatic test_branch();
    logic [31:0] pre_alu[4];
    logic [31:0] br_alu[4];
    logic [1:0]  br_src[4];
    logic        br_pcw[4];
    logic        br_zero[4];
    logic [31:0] br_pc[4];
    // beq with offset 8 in IR
    mem_rdata = {1'b0, 6'b0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'b1100011};
    IRwrite = 1; fc_m = (fc_m + 1) & 32'hF;
    step();
    IRwrite = 0;
    pre_alu[0] = 32'h20; br_alu[0] = 32'h999; br_src[0] = 2'b01; br_pcw[0] = 0; br_zero[0] = 1; br_pc[0] = 32'h20;
    pre_alu[1] = 32'h40; br_alu[1] = 32'h999; br_src[1] = 2'b01; br_pcw[1] = 0; br_zero[1] = 0; br_pc[1] = 32'h20;
    pre_alu[2] = 32'h80; br_alu[2] = 32'h37;  br_src[2] = 2'b10; br_pcw[2] = 1; br_zero[2] = 0; br_pc[2] = 32'h36;
    pre_alu[3] = 32'h90; br_alu[3] = 32'h55;  br_src[3] = 2'b00; br_pcw[3] = 0; br_zero[3] = 1; br_pc[3] = 32'h55;
    for (int i = 0; i < 4; i++) begin
      alu_result = pre_alu[i];
      step();
      PCwrite_cond = 1; PCwrite = br_pcw[i]; alu_zero = br_zero[i]; PCsrc = br_src[i];
      alu_result = br_alu[i];
      push("br_pc", br_pc[i]); push("br_link", br_pc[i]);
      step();
      ctrl_idle();
      e = sb.pop_front(); checks++;
      if (mem_addr !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, mem_addr, e.val); end
      Memtoreg = 2'b10; #1;
      e = sb.pop_front(); checks++;
      if (rf_wdata !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, rf_wdata, e.val); end
      Memtoreg = 2'b00;
      $display("branch %0d: zero=%0b src=%0d pc=%h", i, br_zero[i], br_src[i], mem_addr);
    end
  endtask

  task automatic test_load_store();
    alu_result = 32'h100; rf_rdata1 = 32'h1111_1111; rf_rdata2 = 32'hCAFE_F00D;
    step();
    IorD = 1; Memread = 1; Memwrite = 1; ALUsrcA = 1;
    mem_rdata = 32'hDEAD_BEEF; alu_result = 32'h77; rf_rdata1 = 0; rf_rdata2 = 0;
    #1;
    push("ls_addr", 32'h100); push("ls_re", 32'h1); push("ls_we", 32'h1);
    push("ls_wdata", 32'hCAFE_F00D); push("ls_alu_a", 32'h1111_1111); push("ls_alu_b_b", 32'hCAFE_F00D);
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(mem_re) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_re, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(mem_we) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_we, e.val); end
    e = sb.pop_front(); checks++;
    if (mem_wdata !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_wdata, e.val); end
    e = sb.pop_front(); checks++;
    if (alu_a !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, alu_a, e.val); end
    e = sb.pop_front(); checks++;
    if (alu_b !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, alu_b, e.val); end
    push("wb_mdr", 32'hDEAD_BEEF); push("wb_rd", 32'd8); push("wb_aluout", 32'h77);
    push("wb_zero", 32'h0); push("wb_we_off", 32'h0); push("wb_re_off", 32'h0); push("wb_pc", 32'h55);
    step();
    ctrl_idle();
    Memtoreg = 2'b01; RegDst = 1; #1;
    e = sb.pop_front(); checks++;
    if (rf_wdata !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_wdata, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(rf_waddr) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_waddr, e.val); end
    Memtoreg = 2'b00; #1;
    e = sb.pop_front(); checks++;
    if (rf_wdata !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_wdata, e.val); end
    Memtoreg = 2'b11; #1;
    e = sb.pop_front(); checks++;
    if (rf_wdata !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_wdata, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(mem_we) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_we, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(mem_re) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_re, e.val); end
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    ctrl_idle();
    $display("load/store: mdr wb=%h rd=%0d", 32'hDEAD_BEEF, 8);
  endtask

  task automatic test_illegal_reset();
    PCwrite = 1; PCsrc = 2'b11; alu_result = 32'h500;
    push("ill_pc", 32'h55); push("ill_err", 32'h1);
    step();
    ctrl_idle();
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(pcsrc_err) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, pcsrc_err, e.val); end
    push("ill_sticky", 32'h1);
    repeat (3) step();
    e = sb.pop_front(); checks++;
    if (32'(pcsrc_err) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, pcsrc_err, e.val); end
    rf_rdata1 = 32'hA5A5; rf_rdata2 = 32'h5A5A; mem_rdata = 32'h00A00093; alu_result = 32'h321;
    step();
    // mid-cycle asynchronous assertion, checked well before the next edge
    #2 rst = 0;
    #1;
    push("ar_pc", 32'h0); push("ar_err", 32'h0); push("ar_op", 32'h0); push("ar_fc", 32'h0);
    push("ar_aluout", 32'h0); push("ar_mdr", 32'h0); push("ar_a", 32'h0); push("ar_b", 32'h0);
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(pcsrc_err) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, pcsrc_err, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(op_code) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, op_code, e.val); end
    e = sb.pop_front(); checks++;
    if (32'(fetch_count) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, fetch_count, e.val); end
    IorD = 1; #1;
    e = sb.pop_front(); checks++;
    if (mem_addr !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_addr, e.val); end
    Memtoreg = 2'b01; #1;
    e = sb.pop_front(); checks++;
    if (rf_wdata !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, rf_wdata, e.val); end
    ALUsrcA = 1; #1;
    e = sb.pop_front(); checks++;
    if (alu_a !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, alu_a, e.val); end
    e = sb.pop_front(); checks++;
    if (mem_wdata !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, mem_wdata, e.val); end
    ctrl_idle();
    fc_m = 0;
    @(negedge clk);
    rst = 1; rf_rdata1 = 0; rf_rdata2 = 0; alu_result = 0;
    step();
    $display("async reset: pc=%h err=%0b", mem_addr, pcsrc_err);
  endtask

  task automatic test_back_to_back_wrap();
    mem_rdata = 32'h00A00093; IRwrite = 1;
    for (int i = 0; i < 16; i++) begin
      fc_m = (fc_m + 1) & 32'hF;
      push("wrap_fc", fc_m);
      step();
      if (i == 14 || i == 15) begin
        e = sb.pop_front(); checks++;
        if (32'(fetch_count) !== e.val) begin errors++; $display("FAIL %s[%0d] got=%h want=%h", e.name, i, fetch_count, e.val); end
        $display("wrap pulse %0d: fc=%0d", i + 1, fetch_count);
      end else begin
        void'(sb.pop_front());
      end
    end
    IRwrite = 0;
    push("wrap_hold", 32'h0);
    step();
    e = sb.pop_front(); checks++;
    if (32'(fetch_count) !== e.val) begin errors++; $display("FAIL %s got=%h want=%h", e.name, fetch_count, e.val); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0;
    ctrl_idle();
    mem_rdata = 0; rf_rdata1 = 0; rf_rdata2 = 0; alu_result = 0;
    test_reset();
    test_fetch();
    test_imm_decode();
    test_branch();
    test_load_store();
    test_illegal_reset();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
